cpu_mem_arbiter: RTL

Sits directly downstream of cpu_control. Consumes its memory strobes (pc_rd for instruction fetch, ldst_rd/ldst_wr for data) plus the datapath-supplied addresses and store data. Serialises them onto one single-port, Avalon-style word-addressed memory with waitrequest and fixed read latency. Returns fetched words and load data with valid pulses, and drives a stall to the pipeline while any access is outstanding.

---
 rtl/cpu_mem_pkg.sv | 25 ++
 rtl/cpu_mem_req_latch.sv | 44 ++++
 rtl/cpu_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU memory arbiter.
//   arb_state_t      - arbiter FSM states
//   req_type_t       - latched request kind (none / read / write)
//   READ_LATENCY_MAX - largest supported memory read latency
//   LAT_CNT_W        - width of the read-latency down-counter
package cpu_mem_pkg;

  localparam int unsigned READ_LATENCY_MAX = 7;
  localparam int unsigned LAT_CNT_W        = 3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LDST      = 3'd1,
    S_LDST_WAIT = 3'd2,
    S_PC        = 3'd3,
    S_PC_WAIT   = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_WR   = 2'd2
  } req_type_t;

endpackage

// File: rtl/cpu_mem_req_latch.sv
// cpu_mem_req_latch: holds one pending memory request (pending flag, address,
// store data, request type) between strobe sampling and completion.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_load   - capture i_addr/i_data/i_type and set pending
//   i_clear  - drop pending once the request has completed
//   o_pending, o_addr, o_data, o_type - latched request
module cpu_mem_req_latch
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  req_type_t         i_type,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output req_type_t         o_type
);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_pending <= 1'b0;
      o_addr    <= '0;
      o_data    <= '0;
      o_type    <= REQ_NONE;
    end else if (i_load) begin
      o_pending <= 1'b1;
      o_addr    <= i_addr;
      o_data    <= i_data;
      o_type    <= i_type;
    end else if (i_clear) begin
      o_pending <= 1'b0;
      o_type    <= REQ_NONE;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serialises instruction fetches and data loads/stores onto a
// single-port, word-addressed memory with waitrequest and fixed read latency.
// Data accesses are served before fetches.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_pc_rd, i_pc_addr                       - fetch request
//   i_ldst_rd, i_ldst_wr, i_ldst_addr,
//   i_ldst_wrdata                            - load/store request (write wins)
//   o_pc_rddata, o_pc_valid                  - fetched word + completion pulse
//   o_ldst_rddata, o_ldst_valid              - load data + load/store pulse
//   o_stall                                  - access latched but not finished
//   o_mem_addr, o_mem_rd, o_mem_wr,
//   o_mem_wrdata, i_mem_rddata,
//   i_mem_waitrequest                        - memory side
// Optional (macro CPU_MEM_ARB_STATS_EN):
//   o_stat_stall_cycles, o_stat_conflicts    - saturating statistics counters
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pc_rd,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_ldst_rd,
  input  logic              i_ldst_wr,
  input  logic [ADDR_W-1:0] i_ldst_addr,
  input  logic [DATA_W-1:0] i_ldst_wrdata,
  output logic [DATA_W-1:0] o_pc_rddata,
  output logic              o_pc_valid,
  output logic [DATA_W-1:0] o_ldst_rddata,
  output logic              o_ldst_valid,
  output logic              o_stall,
`ifdef CPU_MEM_ARB_STATS_EN
  output logic [31:0]       o_stat_stall_cycles,
  output logic [15:0]       o_stat_conflicts,
`endif
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  input  logic [DATA_W-1:0] i_mem_rddata,
  input  logic              i_mem_waitrequest
);

  arb_state_t           state, state_nxt;
  logic [LAT_CNT_W-1:0] lat_cnt;

  logic                 pc_load, pc_clear, pc_pending;
  logic [ADDR_W-1:0]    pc_addr;
  logic [DATA_W-1:0]    pc_data;
  req_type_t            pc_type;

  logic                 ldst_load, ldst_clear, ldst_pending;
  logic [ADDR_W-1:0]    ldst_addr;
  logic [DATA_W-1:0]    ldst_data;
  req_type_t            ldst_type;
  req_type_t            ldst_type_in;

  logic                 lat_done;

  // Strobes are only looked at while idle; under stall the pipeline holds them.
  assign pc_load      = (state == S_IDLE) && i_pc_rd;
  assign ldst_load    = (state == S_IDLE) && (i_ldst_rd || i_ldst_wr);
  assign ldst_type_in = i_ldst_wr ? REQ_WR : REQ_RD;
  assign lat_done     = (lat_cnt == '0);

  // A request completes when a write is accepted or read data is captured.
  assign ldst_clear = ((state == S_LDST) && !i_mem_waitrequest && (ldst_type == REQ_WR)) ||
                      ((state == S_LDST_WAIT) && lat_done);
  assign pc_clear   = ((state == S_PC) && !i_mem_waitrequest && (pc_type == REQ_WR)) ||
                      ((state == S_PC_WAIT) && lat_done);

  cpu_mem_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pc_latch (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (pc_load),
    .i_clear   (pc_clear),
    .i_addr    (i_pc_addr),
    .i_data    ('0),
    .i_type    (REQ_RD),
    .o_pending (pc_pending),
    .o_addr    (pc_addr),
    .o_data    (pc_data),
    .o_type    (pc_type)
  );

  cpu_mem_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ldst_latch (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (ldst_load),
    .i_clear   (ldst_clear),
    .i_addr    (i_ldst_addr),
    .i_data    (i_ldst_wrdata),
    .i_type    (ldst_type_in),
    .o_pending (ldst_pending),
    .o_addr    (ldst_addr),
    .o_data    (ldst_data),
    .o_type    (ldst_type)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ldst_load)    state_nxt = S_LDST;
        else if (pc_load) state_nxt = S_PC;
      end
      S_LDST: begin
        if (!i_mem_waitrequest) begin
          if (ldst_type == REQ_WR) state_nxt = pc_pending ? S_PC : S_IDLE;
          else                     state_nxt = S_LDST_WAIT;
        end
      end
      S_LDST_WAIT: begin
        if (lat_done) state_nxt = pc_pending ? S_PC : S_IDLE;
      end
      S_PC: begin
        if (!i_mem_waitrequest) state_nxt = (pc_type == REQ_WR) ? S_IDLE : S_PC_WAIT;
      end
      S_PC_WAIT: begin
        if (lat_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory outputs come straight from the latched request of the side being
  // served, so they stay stable for as long as waitrequest holds them off.
  always_comb begin
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wrdata = '0;
    if ((state == S_LDST) && ldst_pending) begin
      o_mem_addr = ldst_addr;
      o_mem_rd   = (ldst_type == REQ_RD);
      o_mem_wr   = (ldst_type == REQ_WR);
      if (ldst_type == REQ_WR) o_mem_wrdata = ldst_data;
    end else if ((state == S_PC) && pc_pending) begin
      o_mem_addr = pc_addr;
      o_mem_rd   = (pc_type == REQ_RD);
      o_mem_wr   = (pc_type == REQ_WR);
      if (pc_type == REQ_WR) o_mem_wrdata = pc_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      o_stall       <= 1'b0;
      o_pc_valid    <= 1'b0;
      o_ldst_valid  <= 1'b0;
      o_pc_rddata   <= '0;
      o_ldst_rddata <= '0;
    end else begin
      state        <= state_nxt;
      o_stall      <= (state_nxt != S_IDLE);
      o_pc_valid   <= pc_clear;
      o_ldst_valid <= ldst_clear;

      if (((state == S_LDST) || (state == S_PC)) && !i_mem_waitrequest)
        lat_cnt <= LAT_CNT_W'(READ_LATENCY - 1);
      else if (((state == S_LDST_WAIT) || (state == S_PC_WAIT)) && !lat_done)
        lat_cnt <= lat_cnt - LAT_CNT_W'(1);

      if ((state == S_LDST_WAIT) && lat_done) o_ldst_rddata <= i_mem_rddata;
      if ((state == S_PC_WAIT) && lat_done)   o_pc_rddata   <= i_mem_rddata;
    end
  end

`ifdef CPU_MEM_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_stat_stall_cycles <= '0;
      o_stat_conflicts    <= '0;
    end else begin
      if (o_stall && (o_stat_stall_cycles != '1))
        o_stat_stall_cycles <= o_stat_stall_cycles + 32'd1;
      if (pc_load && ldst_load && (o_stat_conflicts != '1))
        o_stat_conflicts <= o_stat_conflicts + 16'd1;
    end
  end
`endif

endmodule
